// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Pipeline-side bundle for the multiply/divide unit: EX-stage
//                request (start/funct/operands) and HI/LO, read-back, status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [5:0]        funct;
    logic [DATA_W-1:0] INa;
    logic [DATA_W-1:0] INb;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] mf_out;
    logic              busy;
    logic              done;
    logic              stall;

    // Pipeline side drives the request and observes results/status
    modport master (
        output start, funct, INa, INb,
        input  HI, LO, mf_out, busy, done, stall
    );

    // Unit side consumes the request and produces results/status
    modport slave (
        input  start, funct, INa, INb,
        output HI, LO, mf_out, busy, done, stall
    );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                Shift-add multiply and restoring divide, one bit per cycle,
//                followed by a sign-fix cycle that commits HI/LO and pulses
//                done. HI/LO instructions arriving while busy are stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    mdu_if.slave      bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    localparam logic [5:0] c_MFHI = 6'b010000;
    localparam logic [5:0] c_MTHI = 6'b010001;
    localparam logic [5:0] c_MFLO = 6'b010010;
    localparam logic [5:0] c_MTLO = 6'b010011;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic [DATA_W-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [2*DATA_W-1:0] r_acc;      // {partial product, remaining multiplier}
    logic [DATA_W:0]     r_rem;      // working remainder
    logic [DATA_W-1:0]   r_quo;      // dividend shifting out, quotient in
    logic [DATA_W-1:0]   r_orig_a;   // returned in HI on divide-by-zero
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic                r_is_div;

    logic                w_hilo;
    logic                w_muldiv;
    logic                w_signed;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_madd;
    logic [DATA_W+1:0]   w_shift;
    logic [DATA_W+1:0]   w_diff;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_last;

    // The eight HI/LO functs are 0100xx and 0110xx
    assign w_hilo   = (bus.funct[5:4] == 2'b01) && !bus.funct[2];
    assign w_muldiv = (bus.funct[5:2] == 4'b0110);
    assign w_signed = !bus.funct[0];
    assign w_abs_a  = (w_signed && bus.INa[DATA_W-1]) ? (~bus.INa + 1'b1) : bus.INa;
    assign w_abs_b  = (w_signed && bus.INb[DATA_W-1]) ? (~bus.INb + 1'b1) : bus.INb;
    assign w_last   = (r_cnt == {CNT_W{1'b1}});

    // Shift-add step: add multiplicand to upper half when current LSB is set
    assign w_madd   = r_acc[0] ? ({1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opb})
                               :  {1'b0, r_acc[2*DATA_W-1:DATA_W]};

    // Restoring step: a set top bit of the trial difference means "restore"
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff   = w_shift - {2'b00, r_opb};

    assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;

    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.done   = r_done;
    assign bus.busy   = (r_state != c_ST_IDLE);
    assign bus.stall  = bus.start && bus.busy && w_hilo;
    assign bus.mf_out = (bus.funct == c_MFHI) ? r_hi :
                        (bus.funct == c_MFLO) ? r_lo : '0;

    // Sequencer: accept request, iterate 32 times, commit with sign fix
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_orig_a <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.funct == c_MTHI) r_hi <= bus.INa;
                        if (bus.funct == c_MTLO) r_lo <= bus.INa;
                        if (w_muldiv) begin
                            r_opb    <= w_abs_b;
                            r_neg_q  <= w_signed && (bus.INa[DATA_W-1] ^ bus.INb[DATA_W-1]);
                            r_neg_r  <= w_signed && bus.INa[DATA_W-1];
                            r_div0   <= (bus.INb == '0);
                            r_orig_a <= bus.INa;
                            r_cnt    <= '0;
                            r_is_div <= bus.funct[1];
                            if (bus.funct[1]) begin
                                r_quo   <= w_abs_a;
                                r_rem   <= '0;
                                r_state <= c_ST_DIV;
                            end else begin
                                r_acc   <= {{DATA_W{1'b0}}, w_abs_a};
                                r_state <= c_ST_MUL;
                            end
                        end
                    end
                end
                c_ST_MUL: begin
                    r_acc <= {w_madd, r_acc[DATA_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= c_ST_FIX;
                end
                c_ST_DIV: begin
                    if (w_diff[DATA_W+1]) begin
                        r_rem <= w_shift[DATA_W:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[DATA_W:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= c_ST_FIX;
                end
                c_ST_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod[DATA_W-1:0];
                    end else if (r_div0) begin
                        r_hi <= r_orig_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= r_neg_r ? (~r_rem[DATA_W-1:0] + 1'b1) : r_rem[DATA_W-1:0];
                        r_lo <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                    end
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Directed self-checking bench for mdu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam logic [5:0] c_MFHI  = 6'b010000;
    localparam logic [5:0] c_MTHI  = 6'b010001;
    localparam logic [5:0] c_MFLO  = 6'b010010;
    localparam logic [5:0] c_MTLO  = 6'b010011;
    localparam logic [5:0] c_MULT  = 6'b011000;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIV   = 6'b011010;
    localparam logic [5:0] c_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    mdu_if #(.DATA_W(32)) bus ();

    mdu_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div and check the full E0..E33 timeline and the result
    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.start = 1'b1;
        bus.funct = f;
        bus.INa   = a;
        bus.INb   = b;
        step();                                  // E0
        bus.start = 1'b0;
        bus.INa   = ~a;                          // must not disturb the op
        bus.INb   = b ^ 32'h0F0F_0F0F;
        chk({tag, " busy@E0"}, {31'd0, bus.busy}, 32'd1);
        repeat (32) step();                      // E1..E32
        chk({tag, " done@E32"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " busy@E32"}, {31'd0, bus.busy}, 32'd1);
        step();                                  // E33
        chk({tag, " done@E33"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " busy@E33"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " HI"}, bus.HI, exp_hi);
        chk({tag, " LO"}, bus.LO, exp_lo);
        step();
        chk({tag, " done pulse width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.funct = 6'd0;
        bus.INa   = 32'd0;
        bus.INb   = 32'd0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);

        // MTLO then MFLO from IDLE; unknown funct ignored
        bus.start = 1'b1;
        bus.funct = c_MTLO;
        bus.INa   = 32'h0000_1234;
        step();
        chk("MTLO LO", bus.LO, 32'h0000_1234);
        bus.funct = c_MFLO;
        #1;
        chk("MFLO mf_out", bus.mf_out, 32'h0000_1234);
        chk("MFLO stall", {31'd0, bus.stall}, 32'd0);
        bus.funct = 6'b100000;
        bus.INa   = 32'hDEAD_BEEF;
        step();
        chk("unknown busy", {31'd0, bus.busy}, 32'd0);
        chk("unknown LO", bus.LO, 32'h0000_1234);
        chk("unknown HI", bus.HI, 32'd0);
        chk("unknown mf_out", bus.mf_out, 32'd0);
        bus.start = 1'b0;

        // Multiplies
        run_op("MULT -1*-1", c_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("MULTU max*max", c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("MULT -3*5", c_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Divides
        run_op("DIV -7/2", c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("DIVU 7/2", c_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("DIV 7/-2", c_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("DIV ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("DIVU 5/0", c_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

        // HI/LO instructions stall while a MULT is in flight (HI currently 5)
        bus.start = 1'b1;
        bus.funct = c_MULT;
        bus.INa   = 32'd2;
        bus.INb   = 32'd3;
        step();                                  // E0
        bus.INa = 32'h0000_AAAA;
        for (int i = 0; i < 33; i++) begin
            bus.funct = (i % 2 == 0) ? c_MTHI : c_MFHI;
            #1;
            chk("stall while busy", {31'd0, bus.stall}, 32'd1);
            chk("HI held while busy", bus.HI, 32'd5);
            if (i % 2 == 1) chk("mf_out old HI", bus.mf_out, 32'd5);
            step();
        end
        bus.funct = c_MTHI;
        #1;
        chk("stall@done", {31'd0, bus.stall}, 32'd0);
        chk("done before MTHI", {31'd0, bus.done}, 32'd1);
        chk("MULT 2*3 HI", bus.HI, 32'd0);
        chk("MULT 2*3 LO", bus.LO, 32'd6);
        step();
        chk("MTHI after release", bus.HI, 32'h0000_AAAA);
        bus.funct = c_MFHI;
        #1;
        chk("MFHI after release", bus.mf_out, 32'h0000_AAAA);
        bus.start = 1'b0;
        step();

        // Reset in the middle of a DIV aborts it
        bus.start = 1'b1;
        bus.funct = c_DIVU;
        bus.INa   = 32'd100;
        bus.INb   = 32'd7;
        step();                                  // E0
        bus.start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort HI", bus.HI, 32'd0);
        chk("abort LO", bus.LO, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 24; i++) begin
            step();
            chk("abort no late done", {31'd0, bus.done}, 32'd0);
        end
        run_op("MULT 3*4", c_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
